pipe_hazard_ctrl: RTL

- Backward-direction control for the 5-stage LEGv8 pipeline. It takes the state held in the IF/ID, ID/EX and EX/MEM pipeline registers and returns write-enable, bubble and flush controls to those registers and to the PC.
- Handles three cases: load-use stalls, flushes for branches resolved in MEM, and freezes while a multi-cycle data memory is busy.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/sat_counter.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_XZR = 5'd31;
    localparam logic [31:0] NOP_IC = 32'h0;

    // RUN: normal flow; MEM_WAIT: frozen on a slow data access; MEM_ERR: frozen until reset
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hazard_state_e;

    // A load in EX whose destination feeds the instruction in ID; XZR is never a real producer
    function automatic logic load_use_hit(
        input logic             id_valid,
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_wr,
        input logic [REG_W-1:0] id_rn,
        input logic [REG_W-1:0] id_rm,
        input logic             id_uses_rm
    );
        return id_valid & ex_mem_read & (ex_wr != REG_XZR) &
               ((ex_wr == id_rn) | (id_uses_rm & (ex_wr == id_rm)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for perf-debug counts.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    // Falling-edge register, aligned with the pipeline registers; clr_n clears asynchronously
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Backward-direction pipeline control: load-use stalls, MEM-stage branch flushes and
// data-memory freezes, with saturating stall/flush counters.
//
// Data-memory handshake: mem_req is held high by EX/MEM for the whole access; the access
// completes in the cycle mem_ready is high (mem_req & mem_ready). While mem_req is high and
// mem_ready low, the pipeline is frozen and EX/MEM keeps presenting the same request.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             mem_isZeroBranch,
    input  logic             mem_isUnconBranch,
    input  logic             mem_alu_zero,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write_en,
    output logic             pc_src,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_write_en,
    output logic             idex_bubble,
    output logic             exmem_write_en,
    output logic             exmem_bubble,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       dbg_state
);

    // Wide enough to hold MEM_TIMEOUT plus headroom so the compare never aliases
    localparam int TO_W = $clog2(MEM_TIMEOUT + 2) + 1;
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    hazard_state_e   state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mem_error_q, mem_error_d;

    logic memhaz;
    logic taken;
    logic loaduse;
    logic freeze;
    logic stall_inc;
    logic flush_inc;

    assign memhaz  = mem_req & ~mem_ready;
    assign taken   = mem_isUnconBranch | (mem_isZeroBranch & mem_alu_zero);
    assign loaduse = load_use_hit(id_valid, ex_memRead, ex_write_reg, id_rn, id_rm, id_uses_rm);

    // Next state, timeout tracking and the combinational pipeline controls
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        mem_error_d = mem_error_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        pc_write_en    = 1'b1;
        pc_src         = 1'b0;
        ifid_write_en  = 1'b1;
        ifid_flush     = 1'b0;
        idex_write_en  = 1'b1;
        idex_bubble    = 1'b0;
        exmem_write_en = 1'b1;
        exmem_bubble   = 1'b0;
        memwb_bubble   = 1'b0;

        unique case (state_q)
            RUN:      freeze = memhaz;
            MEM_WAIT: freeze = ~mem_ready;
            default:  freeze = 1'b1;
        endcase

        if (freeze) begin
            // Hold every register; only MEM/WB advances, carrying a bubble
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            memwb_bubble   = 1'b1;
            if (state_q == RUN) begin
                stall_inc = 1'b1;
                state_d   = MEM_WAIT;
                to_cnt_d  = TO_ONE;
            end else if (state_q == MEM_WAIT) begin
                stall_inc = 1'b1;
                if (MEM_TIMEOUT != 0) begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                    if (to_cnt_d >= TO_LIMIT) begin
                        state_d     = MEM_ERR;
                        mem_error_d = 1'b1;
                    end
                end
            end
        end else begin
            // RUN evaluation; also the release cycle out of MEM_WAIT
            state_d  = RUN;
            to_cnt_d = '0;
            if (taken) begin
                // Squash IF/ID, ID/EX and EX/MEM wrong-path work; load-use in ID is moot
                pc_src       = 1'b1;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
                flush_inc    = 1'b1;
            end else if (loaduse) begin
                // Hold PC and IF/ID one cycle while a bubble lets the load reach MEM
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
                stall_inc     = 1'b1;
            end
        end

        if (!RESET_N) begin
            pc_write_en    = 1'b0;
            pc_src         = 1'b0;
            ifid_write_en  = 1'b0;
            ifid_flush     = 1'b1;
            idex_write_en  = 1'b0;
            idex_bubble    = 1'b1;
            exmem_write_en = 1'b0;
            exmem_bubble   = 1'b1;
            memwb_bubble   = 1'b1;
            stall_inc      = 1'b0;
            flush_inc      = 1'b0;
        end
    end

    // State, timeout counter and sticky error flag, on the pipeline's falling edge
    always_ff @(negedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= RUN;
            to_cnt_q    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLOCK),
        .clr_n (RESET_N),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLOCK),
        .clr_n (RESET_N),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign mem_error = mem_error_q;
    assign dbg_state = state_q;

endmodule
